// File: rtl/csa_seq_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - B_in, one 4-bit carry-select slice per clock, LSB first.
// States: IDLE = waiting for operands | RUN = one slice per edge | DONE = result held until taken.
module csa_seq_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             V
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic [3:0] a_sl, b_sl;
  logic [4:0] cand0, cand1, sel;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*4 +: 4];
        b_sl = nb_q[i*4 +: 4];
      end
    end
  end

  // Both carry-in candidates exist every cycle; the registered carry picks one.
  assign cand0 = {1'b0, a_sl} + {1'b0, b_sl};
  assign cand1 = {1'b0, a_sl} + {1'b0, b_sl} + 5'd1;
  assign sel   = carry_q ? cand1 : cand0;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          nb_d    = ~B;
          carry_d = ~B_in;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (k_q == KW'(i)) diff_d[i*4 +: 4] = sel[3:0];
        end
        carry_d = sel[4];
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          bout_d  = ~sel[4];
          // Operand signs equal after inverting B means A and B had opposite signs.
          v_d     = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sel[3] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign B_out     = bout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_csa_seq_subtractor.sv
// Bench for csa_seq_subtractor: WIDTH=16 and WIDTH=4 instances against a transaction-level model.
module tb_csa_seq_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  in_valid_s, out_ready_s, bin_s;
  logic [15:0] a_s [2];
  logic [15:0] b_s [2];
  wire  [1:0]  o_ready, o_valid, o_bout, o_v;
  wire  [15:0] diff16;
  wire  [3:0]  diff4;

  csa_seq_subtractor #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(o_ready[0]),
    .A(a_s[0]), .B(b_s[0]), .B_in(bin_s[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready_s[0]), .Diff(diff16), .B_out(o_bout[0]), .V(o_v[0]));

  csa_seq_subtractor #(.WIDTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(o_ready[1]),
    .A(a_s[1][3:0]), .B(b_s[1][3:0]), .B_in(bin_s[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready_s[1]), .Diff(diff4), .B_out(o_bout[1]), .V(o_v[1]));

  // Reference arithmetic: plain integer subtraction in the instance's width.
  function automatic int wd(input int d);
    return (d == 0) ? 16 : 4;
  endfunction
  function automatic int msk(input int d);
    return (1 << wd(d)) - 1;
  endfunction
  function automatic int sgn(input int d, input int x);
    return (x >= (1 << (wd(d) - 1))) ? x - (1 << wd(d)) : x;
  endfunction
  function automatic int ref_diff(input int d, input int a, input int b, input int bin);
    return (a - b - bin) & msk(d);
  endfunction
  function automatic bit ref_bout(input int a, input int b, input int bin);
    return a < b + bin;
  endfunction
  function automatic bit ref_v(input int d, input int a, input int b, input int bin);
    int r;
    r = sgn(d, a) - sgn(d, b) - bin;
    return (r > (1 << (wd(d) - 1)) - 1) || (r < -(1 << (wd(d) - 1)));
  endfunction
  function automatic int opa(input int d);
    return int'({16'h0, a_s[d]}) & msk(d);
  endfunction
  function automatic int opb(input int d);
    return int'({16'h0, b_s[d]}) & msk(d);
  endfunction
  function automatic int dut_diff(input int d);
    return (d == 0) ? int'({16'h0, diff16}) : int'({28'h0, diff4});
  endfunction

  // Transaction-level model: accept, wait NSLICE edges, present, wait for consumer.
  bit m_ready [2];
  bit m_valid [2];
  int m_cnt   [2];
  int m_diff  [2];
  bit m_bout  [2];
  bit m_v     [2];
  int p_diff  [2];
  bit p_bout  [2];
  bit p_v     [2];
  int acc_cnt [2] = '{0, 0};
  int acc_cyc [2] = '{0, 0};
  int cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ready[d] <= 1'b1;
        m_valid[d] <= 1'b0;
        m_cnt[d]   <= 0;
        m_diff[d]  <= 0;
        m_bout[d]  <= 1'b0;
        m_v[d]     <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (m_ready[d] && in_valid_s[d]) begin
          p_diff[d]  <= ref_diff(d, opa(d), opb(d), int'({31'h0, bin_s[d]}));
          p_bout[d]  <= ref_bout(opa(d), opb(d), int'({31'h0, bin_s[d]}));
          p_v[d]     <= ref_v(d, opa(d), opb(d), int'({31'h0, bin_s[d]}));
          m_ready[d] <= 1'b0;
          m_cnt[d]   <= wd(d) / 4;
          acc_cnt[d] <= acc_cnt[d] + 1;
          acc_cyc[d] <= cyc;
        end else if (m_cnt[d] > 0) begin
          m_cnt[d] <= m_cnt[d] - 1;
          if (m_cnt[d] == 1) begin
            m_valid[d] <= 1'b1;
            m_diff[d]  <= p_diff[d];
            m_bout[d]  <= p_bout[d];
            m_v[d]     <= p_v[d];
          end
        end else if (m_valid[d] && out_ready_s[d]) begin
          m_valid[d] <= 1'b0;
          m_ready[d] <= 1'b1;
        end
      end
    end
  end

  // Hand-computed expectations for the directed WIDTH=16 operations, in issue order.
  logic [15:0] lit_diff [8];
  logic        lit_bout [8];
  logic        lit_v    [8];
  int lit_n   = 0;
  int tmo_cnt = 0;

  int checks   = 0;
  int errors   = 0;
  int lit_rd   = 0;
  int tmo_seen = 0;
  bit prev_v [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (width %0d) cyc %0d: got %0h, expected %0h", nm, wd(d), cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) chk("in_ready", d, int'(o_ready[d]), int'(m_ready[d]));
      chk("out_valid", d, int'(o_valid[d]), int'(m_valid[d]));
      if (m_cnt[d] == 0) begin
        chk("Diff", d, dut_diff(d), m_diff[d]);
        chk("B_out", d, int'(o_bout[d]), int'(m_bout[d]));
        chk("V", d, int'(o_v[d]), int'(m_v[d]));
      end
      if (d == 0 && rst_n && o_valid[0] && !prev_v[0] && lit_rd < lit_n) begin
        chk("lit_Diff", 0, int'({16'h0, diff16}), int'({16'h0, lit_diff[lit_rd]}));
        chk("lit_B_out", 0, int'(o_bout[0]), int'(lit_bout[lit_rd]));
        chk("lit_V", 0, int'(o_v[0]), int'(lit_v[lit_rd]));
        chk("lit_latency", 0, cyc - acc_cyc[0] - 1, 4);
        lit_rd++;
      end
      prev_v[d] = o_valid[d];
    end
    if (tmo_cnt != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d expired waits, expected 0", tmo_cnt);
      tmo_seen = tmo_cnt;
    end
  end

  task automatic push_lit(input logic [15:0] ed, input logic eb, input logic ev);
    lit_diff[lit_n] = ed;
    lit_bout[lit_n] = eb;
    lit_v[lit_n]    = ev;
    lit_n++;
  endtask

  task automatic wait_accept(input int d);
    int s, n;
    s = acc_cnt[d];
    n = 0;
    while (acc_cnt[d] == s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt[d] == s) tmo_cnt++;
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (!m_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready[d]) tmo_cnt++;
  endtask

  task automatic dir_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic ev);
    push_lit(ed, eb, ev);
    @(negedge clk);
    in_valid_s[0]  = 1'b1;
    a_s[0]         = a;
    b_s[0]         = b;
    bin_s[0]       = bin;
    out_ready_s[0] = 1'b1;
    wait_accept(0);
    in_valid_s[0] = 1'b0;
    a_s[0]        = 16'($urandom);
    b_s[0]        = 16'($urandom);
    bin_s[0]      = 1'($urandom);
    wait_ready(0);
  endtask

  task automatic rand_run(input int d, input int n_ops);
    int s, c;
    s = acc_cnt[d];
    c = 0;
    while (acc_cnt[d] - s < n_ops && c < 60000) begin
      @(negedge clk);
      in_valid_s[d]  = ($urandom % 4) != 0;
      a_s[d]         = 16'($urandom);
      b_s[d]         = 16'($urandom);
      bin_s[d]       = 1'($urandom);
      out_ready_s[d] = ($urandom % 3) != 0;
      c++;
    end
    if (acc_cnt[d] - s < n_ops) tmo_cnt++;
    in_valid_s[d]  = 1'b0;
    out_ready_s[d] = 1'b1;
  endtask

  initial begin
    int n;
    in_valid_s  = '0;
    out_ready_s = '0;
    bin_s       = '0;
    a_s[0] = '0; a_s[1] = '0;
    b_s[0] = '0; b_s[1] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    dir_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    dir_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    dir_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    dir_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    dir_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure: result held for 10 cycles while operands keep changing.
    push_lit(16'h00F0, 1'b0, 1'b0);
    @(negedge clk);
    out_ready_s[0] = 1'b0;
    in_valid_s[0]  = 1'b1;
    a_s[0] = 16'h0100; b_s[0] = 16'h0010; bin_s[0] = 1'b0;
    wait_accept(0);
    n = 0;
    while (!m_valid[0] && n < 100) begin
      @(negedge clk);
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); bin_s[0] = 1'($urandom);
      n++;
    end
    if (!m_valid[0]) tmo_cnt++;
    repeat (10) begin
      @(negedge clk);
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); bin_s[0] = 1'($urandom);
    end
    push_lit(16'h00FF, 1'b0, 1'b0);
    a_s[0] = 16'h0100; b_s[0] = 16'h0001; bin_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    wait_accept(0);
    in_valid_s[0] = 1'b0;
    wait_ready(0);

    // Reset while slice 2 is pending; the in-flight operation must vanish.
    @(negedge clk);
    in_valid_s[0] = 1'b1;
    a_s[0] = 16'hABCD; b_s[0] = 16'h1234; bin_s[0] = 1'b1;
    wait_accept(0);
    in_valid_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    dir_op(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0);

    fork
      rand_run(0, 4000);
      rand_run(1, 4000);
    join
    repeat (20) @(negedge clk);
    if (lit_rd != lit_n) tmo_cnt++;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
